uart_load_ctrl: RTL and testbench

Sequences UART reprogramming of instruction and data memory.
- Owns the uart_disable / pc_reset handshake toward instruction_mem and the data-memory write port.
- On request, waits for the pipeline to drain, then packs received bytes little-endian into 32-bit words.
- Issues sequential write strobes: address bit ROM_DEPTH = 0 selects instruction memory, 1 selects data memory.
- Returns the CPU to normal fetch with a one-cycle pc_reset.

---
 rtl/uart_load_ctrl_pkg.sv | 15 +
 rtl/uart_load_ctrl_word_asm.sv | 76 +++++++
 rtl/uart_load_ctrl.sv | 131 +++++++++++++
 tb/tb_uart_load_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_load_ctrl_pkg.sv
// Shared definitions for the UART memory loader: data width, default memory
// depth and the loader FSM state encodings.
package uart_load_ctrl_pkg;

  localparam int unsigned ISA_WIDTH      = 32;
  // Default word-address width of each memory.
  localparam int unsigned ROM_DEPTH_DEF  = 14;

  localparam int unsigned UL_STATE_WIDTH = 2;
  localparam logic [UL_STATE_WIDTH-1:0] UL_IDLE = 2'd0;
  localparam logic [UL_STATE_WIDTH-1:0] UL_REQ  = 2'd1;
  localparam logic [UL_STATE_WIDTH-1:0] UL_LOAD = 2'd2;
  localparam logic [UL_STATE_WIDTH-1:0] UL_DONE = 2'd3;

endpackage

// File: rtl/uart_load_ctrl_word_asm.sv
// uart_word_assembler: packs received bytes little-endian into 32-bit words.
//   clk, rst_n  : clock, async active-low reset
//   clear       : restart at lane 0 (start of a new load)
//   byte_en     : accept byte_in into the current lane
//   word_ready  : one-cycle pulse, word holds the completed word
//   resid_ok_c  : (UART_LOAD_CHECKSUM_EN only) residual is exactly one byte
//                 equal to the XOR of all bytes of completed words
module uart_word_assembler
  import uart_load_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 byte_en,
  input  logic [7:0]           byte_in,
  output logic                 word_ready,
  output logic [ISA_WIDTH-1:0] word
`ifdef UART_LOAD_CHECKSUM_EN
  ,
  output logic                 resid_ok_c
`endif
);

  logic [1:0]           lane_q;
  logic [ISA_WIDTH-1:0] shift_q;

  // Shift bytes in from the top so that after four bytes lane 0 sits in [7:0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q     <= 2'd0;
      shift_q    <= '0;
      word       <= '0;
      word_ready <= 1'b0;
    end else begin
      word_ready <= 1'b0;
      if (clear) begin
        lane_q  <= 2'd0;
        shift_q <= '0;
      end else if (byte_en) begin
        shift_q <= {byte_in, shift_q[ISA_WIDTH-1:8]};
        lane_q  <= lane_q + 2'd1;
        if (lane_q == 2'd3) begin
          word       <= {byte_in, shift_q[ISA_WIDTH-1:8]};
          word_ready <= 1'b1;
        end
      end
    end
  end

`ifdef UART_LOAD_CHECKSUM_EN
  logic [7:0] part_xor_q;
  logic [7:0] data_xor_q;

  // part_xor covers the open word; it folds into data_xor when the word completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      part_xor_q <= 8'd0;
      data_xor_q <= 8'd0;
    end else if (clear) begin
      part_xor_q <= 8'd0;
      data_xor_q <= 8'd0;
    end else if (byte_en) begin
      if (lane_q == 2'd3) begin
        data_xor_q <= data_xor_q ^ part_xor_q ^ byte_in;
        part_xor_q <= 8'd0;
      end else begin
        part_xor_q <= part_xor_q ^ byte_in;
      end
    end
  end

  // With one residual byte, part_xor is that byte.
  assign resid_ok_c = (lane_q == 2'd1) && (part_xor_q == data_xor_q);
`endif

endmodule

// File: rtl/uart_load_ctrl.sv
// uart_load_ctrl: sequences UART reprogramming of instruction/data memory.
// Waits for the pipeline to drain, takes the memories (uart_disable=0), writes
// assembled words to sequential addresses (top address bit selects data memory),
// ends on an idle timeout or a full address space, then pulses pc_reset.
//   uart_req/pipe_idle      : programming request / pipeline drained
//   rx_valid/rx_data        : received byte strobe and data
//   upg_wen/upg_adr/upg_dat : memory write port
//   uart_disable, pc_reset  : handshake toward instruction memory and PC
//   loading, load_err, word_cnt : status
// Optional macro UART_LOAD_CHECKSUM_EN: trailing XOR checksum byte, load_err.
module uart_load_ctrl
  import uart_load_ctrl_pkg::*;
#(
  parameter int unsigned ROM_DEPTH      = ROM_DEPTH_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned CNT_W          = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 uart_req,
  input  logic                 pipe_idle,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  output logic                 uart_disable,
  output logic                 upg_wen,
  output logic [ROM_DEPTH:0]   upg_adr,
  output logic [ISA_WIDTH-1:0] upg_dat,
  output logic                 pc_reset,
  output logic                 loading,
  output logic                 load_err,
  output logic [ROM_DEPTH+1:0] word_cnt
);

  localparam int unsigned       ADR_W    = ROM_DEPTH + 1;
  localparam int unsigned       WC_W     = ROM_DEPTH + 2;
  localparam logic [ADR_W-1:0]  ADR_MAX  = '1;
  localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [UL_STATE_WIDTH-1:0] state_q;
  logic [UL_STATE_WIDTH-1:0] state_d;
  logic [CNT_W-1:0]          tcnt_q;
  logic                      req_entry;
  logic                      byte_en;
  logic                      full_write;
  logic                      timeout;

  // Next state and per-cycle control decisions.
  always_comb begin
    state_d    = state_q;
    req_entry  = 1'b0;
    full_write = upg_wen && (upg_adr == ADR_MAX);
    byte_en    = 1'b0;
    timeout    = 1'b0;
    case (state_q)
      UL_IDLE: begin
        if (uart_req) begin
          req_entry = 1'b1;
          state_d   = UL_REQ;
        end
      end
      UL_REQ: begin
        if (pipe_idle) state_d = UL_LOAD;
      end
      UL_LOAD: begin
        byte_en = rx_valid && !full_write;
        timeout = !rx_valid && (tcnt_q == TMO_LAST);
        if (full_write || timeout) state_d = UL_DONE;
      end
      UL_DONE: state_d = UL_IDLE;
      default: state_d = UL_IDLE;
    endcase
  end

  // State, handshake outputs, address/word counters and idle timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= UL_IDLE;
      uart_disable <= 1'b1;
      loading      <= 1'b0;
      pc_reset     <= 1'b0;
      upg_adr      <= '0;
      word_cnt     <= '0;
      tcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      uart_disable <= (state_d != UL_LOAD);
      loading      <= (state_d == UL_REQ) || (state_d == UL_LOAD);
      pc_reset     <= (state_d == UL_DONE);
      if (req_entry) begin
        upg_adr  <= '0;
        word_cnt <= '0;
        tcnt_q   <= '0;
      end else begin
        // The address saturates at the last word; the load ends there.
        if (upg_wen) begin
          word_cnt <= word_cnt + WC_W'(1);
          if (!full_write) upg_adr <= upg_adr + ADR_W'(1);
        end
        if (state_q == UL_LOAD) tcnt_q <= rx_valid ? '0 : tcnt_q + CNT_W'(1);
      end
    end
  end

`ifdef UART_LOAD_CHECKSUM_EN
  logic resid_ok_c;

  // Sticky per load; only a timeout (not a full memory) checks the residual.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     load_err <= 1'b0;
    else if (req_entry)             load_err <= 1'b0;
    else if (timeout && !resid_ok_c) load_err <= 1'b1;
  end
`else
  assign load_err = 1'b0;
`endif

  uart_word_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (req_entry),
    .byte_en    (byte_en),
    .byte_in    (rx_data),
    .word_ready (upg_wen),
    .word       (upg_dat)
`ifdef UART_LOAD_CHECKSUM_EN
    ,
    .resid_ok_c (resid_ok_c)
`endif
  );

endmodule

// File: tb/tb_uart_load_ctrl.sv
// Bench for uart_load_ctrl with a small memory (3-bit address) and a short
// idle timeout. A transaction-level model predicts every output each cycle.
module tb_uart_load_ctrl;

  localparam int unsigned RD      = 2;
  localparam int unsigned TMO     = 16;
  localparam int unsigned CW      = 5;
  localparam int          ADR_MAX = (1 << (RD + 1)) - 1;
  localparam int P_IDLE = 0, P_REQ = 1, P_LOAD = 2, P_DONE = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic uart_req = 1'b0;
  logic pipe_idle = 1'b0;
  logic rx_valid = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic uart_disable, upg_wen, pc_reset, loading, load_err;
  logic [RD:0]   upg_adr;
  logic [31:0]   upg_dat;
  logic [RD+1:0] word_cnt;

  always #5 clk = ~clk;

  uart_load_ctrl #(.ROM_DEPTH(RD), .TIMEOUT_CYCLES(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .uart_req(uart_req), .pipe_idle(pipe_idle),
    .rx_valid(rx_valid), .rx_data(rx_data), .uart_disable(uart_disable),
    .upg_wen(upg_wen), .upg_adr(upg_adr), .upg_dat(upg_dat),
    .pc_reset(pc_reset), .loading(loading), .load_err(load_err),
    .word_cnt(word_cnt)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int         m_phase, m_adr, m_wc, m_idle;
  logic [7:0] m_bytes[$];
  logic [7:0] m_xor;
  logic       m_err;
  logic       exp_dis, exp_load, exp_pcr, exp_wen, exp_err;
  logic [31:0] exp_dat;

  task automatic model_reset();
    m_phase = P_IDLE; m_adr = 0; m_wc = 0; m_idle = 0; m_xor = 8'd0; m_err = 1'b0;
    m_bytes.delete();
    exp_dis = 1'b1; exp_load = 1'b0; exp_pcr = 1'b0; exp_wen = 1'b0;
    exp_err = 1'b0; exp_dat = 32'd0;
  endtask

  // Advance one clock: consume this cycle's inputs, produce next cycle's outputs.
  task automatic model_step();
    bit full;
    bit n_wen;
    full  = exp_wen && (m_adr == ADR_MAX);
    n_wen = 1'b0;
    if (exp_wen) begin
      m_wc++;
      if (!full) m_adr++;
    end
    case (m_phase)
      P_IDLE: if (uart_req) begin
        m_phase = P_REQ; m_adr = 0; m_wc = 0; m_idle = 0; m_xor = 8'd0; m_err = 1'b0;
        m_bytes.delete();
      end
      P_REQ: if (pipe_idle) m_phase = P_LOAD;
      P_LOAD: begin
        if (rx_valid) begin
          m_idle = 0;
          if (!full) begin
            m_bytes.push_back(rx_data);
            if (m_bytes.size() == 4) begin
              n_wen   = 1'b1;
              exp_dat = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
              m_xor   = m_xor ^ m_bytes[0] ^ m_bytes[1] ^ m_bytes[2] ^ m_bytes[3];
              m_bytes.delete();
            end
          end
        end else begin
          m_idle++;
        end
        if (full) m_phase = P_DONE;
        else if (m_idle == TMO) begin
          m_phase = P_DONE;
`ifdef UART_LOAD_CHECKSUM_EN
          if (m_bytes.size() != 1) m_err = 1'b1;
          else if (m_bytes[0] != m_xor) m_err = 1'b1;
`endif
        end
      end
      default: m_phase = P_IDLE;
    endcase
    exp_wen  = n_wen;
    exp_dis  = (m_phase != P_LOAD);
    exp_load = (m_phase == P_REQ) || (m_phase == P_LOAD);
    exp_pcr  = (m_phase == P_DONE);
    exp_err  = m_err;
  endtask

  always @(posedge clk) if (rst_n) model_step();

  // ---------------- compare process ----------------
  int          wr_adr_log[$];
  logic [31:0] wr_dat_log[$];
  int          pcr_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("uart_disable", 32'(uart_disable), 32'(exp_dis));
      chk("loading",      32'(loading),      32'(exp_load));
      chk("pc_reset",     32'(pc_reset),     32'(exp_pcr));
      chk("upg_wen",      32'(upg_wen),      32'(exp_wen));
      chk("upg_adr",      32'(upg_adr),      32'(m_adr));
      chk("word_cnt",     32'(word_cnt),     32'(m_wc));
      chk("load_err",     32'(load_err),     32'(exp_err));
      if (exp_wen) chk("upg_dat", upg_dat, exp_dat);
      if (upg_wen) begin
        wr_adr_log.push_back(int'(upg_adr));
        wr_dat_log.push_back(upg_dat);
      end
      if (pc_reset) pcr_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_byte(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b;
    tick();
    rx_valid = 1'b0; rx_data = 8'($urandom);
  endtask

  task automatic start_load(input int wait_cyc);
    uart_req = 1'b1; pipe_idle = 1'b0;
    tick();
    uart_req = 1'b0;
    repeat (wait_cyc) tick();
    pipe_idle = 1'b1;
    tick();
    pipe_idle = 1'($urandom);
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (pc_reset === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_reached", 32'(seen), 32'd1);
  endtask

  task automatic extra_pulses(input int n);
    int p;
    p = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (pc_reset === 1'b1) p++;
    end
    chk("single_pc_reset", 32'(p), 32'd0);
  endtask

  // ---------------- tests ----------------
  initial begin
    logic [7:0] t2[8];
    logic [7:0] b;
    logic [7:0] x;
    int nw, tail, p0;
    t2 = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    model_reset();
    repeat (3) tick();
    chk("reset_disable", 32'(uart_disable), 32'd1);
    chk("reset_adr",     32'(upg_adr),      32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // 1: request while the pipeline is busy
    uart_req = 1'b1; pipe_idle = 1'b0;
    tick();
    uart_req = 1'b0;
    chk("t1_loading", 32'(loading), 32'd1);
    chk("t1_disable_req", 32'(uart_disable), 32'd1);
    repeat (5) tick();
    chk("t1_disable_wait", 32'(uart_disable), 32'd1);
    pipe_idle = 1'b1;
    tick();
    chk("t1_disable_load", 32'(uart_disable), 32'd0);

    // 2: two words, random gaps (gap 0 lands a byte on the write cycle)
    wr_adr_log.delete(); wr_dat_log.delete();
    foreach (t2[i]) begin
      drive_byte(t2[i]);
      repeat ($urandom_range(0, 2)) tick();
    end

    // 3: idle timeout ends the load
    wait_done(TMO + 10);
    chk("t3_word_cnt", 32'(word_cnt), 32'd2);
    chk("t3_disable", 32'(uart_disable), 32'd1);
    extra_pulses(5);
    chk("t2_nwrites", 32'(wr_adr_log.size()), 32'd2);
    if (wr_adr_log.size() == 2) begin
      chk("t2_adr0", 32'(wr_adr_log[0]), 32'd0);
      chk("t2_dat0", wr_dat_log[0], 32'h12345678);
      chk("t2_adr1", 32'(wr_adr_log[1]), 32'd1);
      chk("t2_dat1", wr_dat_log[1], 32'hDEADBEEF);
    end

    // 4: stream 33 words into an 8-word space
    wr_adr_log.delete(); wr_dat_log.delete();
    p0 = pcr_cnt;
    start_load(1);
    for (int i = 0; i < 33 * 4; i++) drive_byte(8'($urandom));
    repeat (3) tick();
    chk("t4_nwrites", 32'(wr_adr_log.size()), 32'd8);
    if (wr_adr_log.size() > 0) chk("t4_last_adr", 32'(wr_adr_log[$]), 32'd7);
    chk("t4_adr_hold", 32'(upg_adr), 32'd7);
    chk("t4_word_cnt", 32'(word_cnt), 32'd8);
    chk("t4_pulses", 32'(pcr_cnt - p0), 32'd1);

    // 5: six bytes then timeout; then a correct checksum byte
    wr_adr_log.delete(); wr_dat_log.delete();
    start_load(0);
    for (int i = 1; i <= 6; i++) drive_byte(8'(i));
    wait_done(TMO + 10);
`ifdef UART_LOAD_CHECKSUM_EN
    chk("t5_err_resid2", 32'(load_err), 32'd1);
`else
    chk("t5_err_resid2", 32'(load_err), 32'd0);
`endif
    chk("t5_nwrites", 32'(wr_adr_log.size()), 32'd1);
    if (wr_dat_log.size() > 0) chk("t5_dat", wr_dat_log[0], 32'h04030201);
    tick();
    start_load(2);
    drive_byte(8'h11); drive_byte(8'h22); drive_byte(8'h44); drive_byte(8'h88);
    drive_byte(8'hFF);
    wait_done(TMO + 10);
    chk("t5_err_ok", 32'(load_err), 32'd0);
    chk("t5_word_cnt", 32'(word_cnt), 32'd1);
    tick();

    // 6: asynchronous reset on a write cycle
    start_load(0);
    drive_byte(8'hA1); drive_byte(8'hA2); drive_byte(8'hA3); drive_byte(8'hA4);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_disable", 32'(uart_disable), 32'd1);
    chk("t6_wen", 32'(upg_wen), 32'd0);
    chk("t6_pc_reset", 32'(pc_reset), 32'd0);
    chk("t6_loading", 32'(loading), 32'd0);
    model_reset();
    repeat (2) tick();
    chk("t6_pc_reset_hold", 32'(pc_reset), 32'd0);
    rst_n = 1'b1;
    tick();
    start_load(1);
    drive_byte(8'hC4); drive_byte(8'hC3); drive_byte(8'hC2); drive_byte(8'hC1);
    chk("t6_restart_wen", 32'(upg_wen), 32'd1);
    chk("t6_restart_adr", 32'(upg_adr), 32'd0);
    chk("t6_restart_dat", upg_dat, 32'hC1C2C3C4);
    wait_done(TMO + 10);
    tick();

    // random loads with noise on uart_req and on rx while idle
    for (int l = 0; l < 8; l++) begin
      for (int i = 0; i < 4; i++) begin
        rx_valid = 1'($urandom); rx_data = 8'($urandom);
        tick();
      end
      rx_valid = 1'b0;
      start_load($urandom_range(0, 4));
      nw = $urandom_range(0, 5);
      x = 8'd0;
      for (int i = 0; i < nw * 4; i++) begin
        b = 8'($urandom);
        x ^= b;
        uart_req = ($urandom_range(0, 3) == 0);
        drive_byte(b);
        repeat ($urandom_range(0, 3)) tick();
      end
      tail = $urandom_range(0, 3);
      if (tail == 1) drive_byte(x);
      else if (tail == 2) drive_byte(8'($urandom));
      else if (tail == 3) begin drive_byte(8'($urandom)); drive_byte(8'($urandom)); end
      uart_req = 1'b0;
      wait_done(TMO + 12);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
